// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if;
  logic [63:0] ImemAddr;
  logic        ImemReq;
  logic        ImemReady;
  logic [31:0] ImemData;

  // Fetch stage drives the request, memory answers with ready/data.
  modport master (
    output ImemAddr,
    output ImemReq,
    input  ImemReady,
    input  ImemData
  );

  modport slave (
    input  ImemAddr,
    input  ImemReq,
    output ImemReady,
    output ImemData
  );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 fetch / next-PC stage: holds the PC, fetches one instruction per
// imem handshake, presents it with Imm26/SignOp, then selects the next PC
// from the branch resolution inputs when downstream accepts it.
module fetch_unit #(
  parameter logic [63:0] START_PC = 64'h0
) (
  input  logic                CLK,
  input  logic                Reset,
  fetch_unit_if.master        imem,
  output logic [31:0]         Instruction,
  output logic                InstrValid,
  output logic [25:0]         Imm26,
  output logic [1:0]          SignOp,
  input  logic                Stall,
  input  logic [63:0]         BusImm,
  input  logic                Branch,
  input  logic                Uncondbranch,
  input  logic                ALUZero,
  output logic [63:0]         PC
);

  typedef enum logic [1:0] {StRst, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [1:0]  sign_op_q, sign_op_d;

  logic        taken;
  logic [63:0] next_pc;

  // Sign-extender control from the opcode bits of the fetched word.
  function automatic logic [1:0] decode_sign_op(input logic [10:0] op);
    logic [1:0] res;
    if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100) begin
      res = 2'b00;  // ADDI / SUBI
    end else if (op == 11'b11111000010 || op == 11'b11111000000) begin
      res = 2'b01;  // LDUR / STUR
    end else if (op[10:5] == 6'b000101) begin
      res = 2'b10;  // B
    end else if (op[10:3] == 8'b10110100) begin
      res = 2'b11;  // CBZ
    end else begin
      res = 2'b00;
    end
    return res;
  endfunction

  // Branch resolution; only consumed on the accept edge in HOLD.
  always_comb begin
    taken   = Uncondbranch | (Branch & ALUZero);
    // Shift drops BusImm[63:62]; 64-bit add wraps.
    next_pc = taken ? (pc_q + (BusImm << 2)) : (pc_q + 64'd4);
  end

  // Next-state logic for the RST -> REQ -> HOLD fetch loop.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    sign_op_d = sign_op_q;
    case (state_q)
      StRst: begin
        state_d = StReq;
        req_d   = 1'b1;
      end
      StReq: begin
        if (imem.ImemReady) begin
          state_d   = StHold;
          req_d     = 1'b0;
          instr_d   = imem.ImemData;
          sign_op_d = decode_sign_op(imem.ImemData[31:21]);
          valid_d   = 1'b1;
        end
      end
      StHold: begin
        if (!Stall) begin
          state_d = StReq;
          req_d   = 1'b1;
          pc_d    = next_pc;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StRst;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset is synchronous and wins over everything.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= StRst;
      pc_q      <= START_PC;
      req_q     <= 1'b0;
      instr_q   <= 32'h0;
      valid_q   <= 1'b0;
      sign_op_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      sign_op_q <= sign_op_d;
    end
  end

  assign imem.ImemReq  = req_q;
  assign imem.ImemAddr = pc_q;
  assign PC            = pc_q;
  assign Instruction   = instr_q;
  assign InstrValid    = valid_q;
  assign SignOp        = sign_op_q;
  assign Imm26         = instr_q[25:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard queue holds the expected
// instruction/SignOp for each word handed to the DUT and is popped when
// InstrValid rises.
module tb_fetch_unit;

  logic        clk;
  logic        Reset;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [25:0] Imm26;
  logic [1:0]  SignOp;
  logic        Stall;
  logic [63:0] BusImm;
  logic        Branch;
  logic        Uncondbranch;
  logic        ALUZero;
  logic [63:0] PC;

  fetch_unit_if imem ();

  fetch_unit #(.START_PC(64'h0)) dut (
    .CLK          (clk),
    .Reset        (Reset),
    .imem         (imem),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .Imm26        (Imm26),
    .SignOp       (SignOp),
    .Stall        (Stall),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .PC           (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  sop;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Immediate that makes a taken branch go from 'from' to 'to'.
  function automatic logic [63:0] br_imm(input logic [63:0] from, input logic [63:0] to);
    logic [63:0] diff;
    diff = to - from;
    return {{2{diff[63]}}, diff[63:2]};
  endfunction

  task automatic wait_req(input logic [63:0] addr);
    int n;
    n = 0;
    while (imem.ImemReq !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (imem.ImemReq !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: ImemReq=%b expected 1", imem.ImemReq);
    end
    checks++;
    if (imem.ImemAddr !== addr) begin
      errors++;
      $display("FAIL req_addr: got %h expected %h", imem.ImemAddr, addr);
    end
    checks++;
    if (PC !== addr) begin
      errors++;
      $display("FAIL req_pc: got %h expected %h", PC, addr);
    end
  endtask

  // Hand one word to the DUT on the ready edge and check the HOLD outputs.
  task automatic deliver(input logic [31:0] data, input logic [1:0] sop);
    exp_t e;
    sb.push_back('{instr: data, sop: sop});
    imem.ImemReady = 1'b1;
    imem.ImemData  = data;
    step();
    imem.ImemReady = 1'b0;
    imem.ImemData  = $urandom;
    e = sb.pop_front();
    checks++;
    if (InstrValid !== 1'b1 || imem.ImemReq !== 1'b0) begin
      errors++;
      $display("FAIL hold_entry: valid=%b req=%b expected 1/0", InstrValid, imem.ImemReq);
    end
    checks++;
    if (Instruction !== e.instr) begin
      errors++;
      $display("FAIL instruction: got %h expected %h", Instruction, e.instr);
    end
    checks++;
    if (SignOp !== e.sop) begin
      errors++;
      $display("FAIL signop: got %b expected %b for %h", SignOp, e.sop, e.instr);
    end
    checks++;
    if (Imm26 !== e.instr[25:0]) begin
      errors++;
      $display("FAIL imm26: got %h expected %h", Imm26, e.instr[25:0]);
    end
  endtask

  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data,
                          input logic [1:0] sop, input int delay, input int stalls,
                          input logic ub, input logic br, input logic az,
                          input logic [63:0] imm, input logic [63:0] exp_next);
    wait_req(addr);
    for (int i = 0; i < delay; i++) begin
      imem.ImemReady = 1'b0;
      imem.ImemData  = $urandom;
      step();
      checks++;
      if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== addr || InstrValid !== 1'b0) begin
        errors++;
        $display("FAIL req_wait: req=%b addr=%h valid=%b expected 1/%h/0",
                 imem.ImemReq, imem.ImemAddr, InstrValid, addr);
      end
    end
    deliver(data, sop);
    for (int i = 0; i < stalls; i++) begin
      Stall          = 1'b1;
      Uncondbranch   = 1'($urandom);
      Branch         = 1'($urandom);
      ALUZero        = 1'($urandom);
      BusImm         = {$urandom, $urandom};
      imem.ImemReady = 1'b1;
      imem.ImemData  = $urandom;
      step();
      checks++;
      if (InstrValid !== 1'b1 || Instruction !== data || SignOp !== sop ||
          PC !== addr || imem.ImemReq !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b instr=%h sop=%b pc=%h req=%b expected 1/%h/%b/%h/0",
                 InstrValid, Instruction, SignOp, PC, imem.ImemReq, data, sop, addr);
      end
    end
    imem.ImemReady = 1'b0;
    Stall          = 1'b0;
    Uncondbranch   = ub;
    Branch         = br;
    ALUZero        = az;
    BusImm         = imm;
    step();
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL accept_valid: got %b expected 0", InstrValid);
    end
    checks++;
    if (PC !== exp_next || imem.ImemAddr !== exp_next || imem.ImemReq !== 1'b1) begin
      errors++;
      $display("FAIL next_pc: pc=%h addr=%h req=%b expected %h/%h/1",
               PC, imem.ImemAddr, imem.ImemReq, exp_next, exp_next);
    end
    Uncondbranch = 1'b0;
    Branch       = 1'b0;
    ALUZero      = 1'b0;
    BusImm       = 64'h0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++;
    if (PC !== 64'h0 || imem.ImemAddr !== 64'h0 || imem.ImemReq !== 1'b0 ||
        Instruction !== 32'h0 || InstrValid !== 1'b0 || SignOp !== 2'b00 || Imm26 !== 26'h0) begin
      errors++;
      $display("FAIL reset_values: pc=%h addr=%h req=%b instr=%h valid=%b sop=%b imm=%h expected all 0",
               PC, imem.ImemAddr, imem.ImemReq, Instruction, InstrValid, SignOp, Imm26);
    end
    Reset = 1'b0;
    step();
    checks++;
    if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 64'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h expected 1/0", imem.ImemReq, imem.ImemAddr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      do_fetch(64'(4 * i), 32'h8B020020, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'(4 * i + 4));
    end
  endtask

  task automatic test_uncond_branch();
    // B -2 from 0x10 back to 0x8, then B +3 from 0x8 to 0x14.
    do_fetch(64'h10, 32'h17FFFFFE, 2'b10, 0, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8);
    do_fetch(64'h8, 32'h14000003, 2'b10, 0, 0, 1'b1, 1'b0, 1'b0, 64'h3, 64'h14);
  endtask

  task automatic test_cbz();
    do_fetch(64'h14, 32'h1400000B, 2'b10, 0, 0, 1'b1, 1'b0, 1'b0, 64'hB, 64'h40);
    do_fetch(64'h40, 32'hB4FFFFE0, 2'b11, 0, 0, 1'b0, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h44);
    do_fetch(64'h44, 32'h17FFFFFF, 2'b10, 0, 0, 1'b1, 1'b0, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h40);
    do_fetch(64'h40, 32'hB4FFFFE0, 2'b11, 0, 0, 1'b0, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h3C);
  endtask

  task automatic test_stall();
    do_fetch(64'h3C, 32'hF8408020, 2'b01, 0, 5, 1'b0, 1'b0, 1'b0, 64'h0, 64'h40);
  endtask

  task automatic test_signop_misc();
    do_fetch(64'h40, 32'h91000421, 2'b00, 4, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h44);
    do_fetch(64'h44, 32'h00000000, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h48);
    do_fetch(64'h48, 32'hF8000000, 2'b01, 1, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4C);
    do_fetch(64'h4C, 32'hD1000000, 2'b00, 0, 1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h50);
  endtask

  task automatic test_wrap();
    do_fetch(64'h50, 32'h14000000, 2'b10, 0, 0, 1'b1, 1'b0, 1'b0,
             br_imm(64'h50, 64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h8B000000, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0,
             64'h0, 64'h0);
  endtask

  task automatic test_zero_imm();
    do_fetch(64'h0, 32'h14000000, 2'b10, 0, 0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    do_fetch(64'h0, 32'h8B020020, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4);
  endtask

  task automatic test_reset_during_req();
    wait_req(64'h4);
    for (int i = 0; i < 4; i++) begin
      imem.ImemReady = 1'b0;
      step();
      checks++;
      if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 64'h4) begin
        errors++;
        $display("FAIL req_stable: req=%b addr=%h expected 1/4", imem.ImemReq, imem.ImemAddr);
      end
    end
    imem.ImemReady = 1'b1;
    imem.ImemData  = 32'h14000003;
    Reset          = 1'b1;
    step();
    imem.ImemReady = 1'b0;
    Reset          = 1'b0;
    checks++;
    if (InstrValid !== 1'b0 || PC !== 64'h0 || imem.ImemReq !== 1'b0 || Instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_req: valid=%b pc=%h req=%b instr=%h expected 0/0/0/0",
               InstrValid, PC, imem.ImemReq, Instruction);
    end
    step();
    checks++;
    if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 64'h0 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL refetch_after_reset: req=%b addr=%h valid=%b expected 1/0/0",
               imem.ImemReq, imem.ImemAddr, InstrValid);
    end
  endtask

  task automatic test_reset_during_hold();
    do_fetch(64'h0, 32'h8B020020, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4);
    wait_req(64'h4);
    deliver(32'h14000005, 2'b10);
    Stall        = 1'b0;
    Uncondbranch = 1'b1;
    BusImm       = 64'h5;
    Reset        = 1'b1;
    step();
    Reset        = 1'b0;
    Uncondbranch = 1'b0;
    BusImm       = 64'h0;
    checks++;
    if (PC !== 64'h0 || InstrValid !== 1'b0 || Instruction !== 32'h0 || SignOp !== 2'b00) begin
      errors++;
      $display("FAIL reset_in_hold: pc=%h valid=%b instr=%h sop=%b expected 0/0/0/0",
               PC, InstrValid, Instruction, SignOp);
    end
    step();
    checks++;
    if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 64'h0) begin
      errors++;
      $display("FAIL req_after_hold_reset: req=%b addr=%h expected 1/0", imem.ImemReq, imem.ImemAddr);
    end
  endtask

  initial begin
    Reset          = 1'b1;
    Stall          = 1'b0;
    BusImm         = 64'h0;
    Branch         = 1'b0;
    Uncondbranch   = 1'b0;
    ALUZero        = 1'b0;
    imem.ImemReady = 1'b0;
    imem.ImemData  = 32'h0;
    test_reset();
    test_sequential();
    test_uncond_branch();
    test_cbz();
    test_stall();
    test_signop_misc();
    test_wrap();
    test_zero_imm();
    test_reset_during_req();
    test_reset_during_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
